// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the program-counter front-end sequencer.
//   state_e  : sequencer states (BOOT, RUN, WAIT)
//   PC_W     : program counter width
//   REG_W    : register-file index width
//   REG_ZERO : hard-wired zero register index (never a real hazard source)
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

  localparam int PC_W  = 32;
  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_ctrl_if
// Bundles every signal between pc_ctrl and the surrounding datapath
// (PC register, IF/ID and ID/EX registers, ID branch logic, instruction memory).
//   master : pc_ctrl side (drives PC / pipeline control, receives datapath state)
//   slave  : datapath side (drives PC value, hazard fields, redirects, imem ack)
// -----------------------------------------------------------------------------
interface pc_ctrl_if;
  import pc_ctrl_pkg::*;

  logic [PC_W-1:0]  pc_i;
  logic [PC_W-1:0]  pc_next_o;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             branch_i;
  logic [PC_W-1:0]  branch_target_i;
  logic             jump_i;
  logic [PC_W-1:0]  jump_target_i;
  logic             imem_req_o;
  logic             imem_ack_i;

  modport master (
    input  pc_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_i, branch_target_i, jump_i, jump_target_i, imem_ack_i,
    output pc_next_o, pc_stall_o, ifid_stall_o, ifid_flush_o,
           idex_bubble_o, imem_req_o
  );

  modport slave (
    output pc_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_i, branch_target_i, jump_i, jump_target_i, imem_ack_i,
    input  pc_next_o, pc_stall_o, ifid_stall_o, ifid_flush_o,
           idex_bubble_o, imem_req_o
  );

endinterface

// File: rtl/pc_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID reads.
//   i_memread : EX-stage instruction is a load
//   i_ex_rt   : EX-stage load destination
//   i_id_rs   : ID-stage source rs
//   i_id_rt   : ID-stage source rt
//   o_lu      : hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
  import pc_ctrl_pkg::*;
(
  input  logic             i_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_lu
);

  // Register zero is constant, so a load targeting it never creates a hazard.
  assign o_lu = i_memread && (i_ex_rt != REG_ZERO) &&
                ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
// Program-counter front-end sequencer. Computes the next PC each cycle and
// produces PC hold, IF/ID stall/flush and ID/EX bubble controls for load-use
// hazards, ID-stage branch/jump redirects and instruction-memory wait states.
// All control outputs are Mealy (combinational from state and inputs).
//
// Ports:
//   clk_i        : clock, rising edge
//   start_i      : asynchronous active-low reset (low returns to BOOT)
//   bus          : pc_ctrl_if.master (datapath/pipeline/imem signals)
//   stall_cnt_o  : cycles with PC held outside BOOT   (PC_CTRL_PERF_EN only)
//   flush_cnt_o  : cycles with IF/ID flushed outside BOOT (PC_CTRL_PERF_EN only)
//
// Build option: define PC_CTRL_PERF_EN to add the saturating perf counters.
// -----------------------------------------------------------------------------
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0,
  parameter int unsigned     PC_STEP     = 4,
  parameter int unsigned     BOOT_CYCLES = 2
)(
  input  logic          clk_i,
  input  logic          start_i,
  pc_ctrl_if.master     bus
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   flush_cnt_o
`endif
);

  localparam logic [PC_W-1:0] STEP      = PC_W'(PC_STEP);
  localparam logic [3:0]      BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e          r_state, w_state_nxt;
  logic [3:0]      r_boot_cnt, w_boot_cnt_nxt;
  logic            r_pend_valid, w_pend_valid_nxt;
  logic [PC_W-1:0] r_pend_target, w_pend_target_nxt;

  logic            w_lu;
  logic            w_rd;
  logic [PC_W-1:0] w_rd_target;

  load_use_detect u_lu (
    .i_memread (bus.idex_memread_i),
    .i_ex_rt   (bus.idex_rt_i),
    .i_id_rs   (bus.ifid_rs_i),
    .i_id_rt   (bus.ifid_rt_i),
    .o_lu      (w_lu)
  );

  // A hazard stall suppresses redirects; the branch re-resolves next cycle.
  assign w_rd        = !w_lu && (bus.jump_i || bus.branch_i);
  assign w_rd_target = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;

  // State register
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state       <= BOOT;
      r_boot_cnt    <= 4'd0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_boot_cnt    <= w_boot_cnt_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt       = r_state;
    w_boot_cnt_nxt    = r_boot_cnt;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    case (r_state)
      BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt    = RUN;
          w_boot_cnt_nxt = 4'd0;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        end
      end
      RUN, WAIT: begin
        if (w_lu) begin
          w_state_nxt = r_state;
        end else if (!bus.imem_ack_i) begin
          w_state_nxt = WAIT;
          // A newer redirect during the wait replaces any older pending one.
          if (w_rd) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = w_rd_target;
          end
        end else begin
          w_state_nxt      = RUN;
          w_pend_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    bus.pc_next_o     = bus.pc_i + STEP;
    bus.pc_stall_o    = 1'b0;
    bus.ifid_stall_o  = 1'b0;
    bus.ifid_flush_o  = 1'b0;
    bus.idex_bubble_o = 1'b0;
    bus.imem_req_o    = 1'b0;
    case (r_state)
      RUN, WAIT: begin
        bus.imem_req_o = 1'b1;
        if (w_lu) begin
          bus.pc_next_o     = bus.pc_i;
          bus.pc_stall_o    = 1'b1;
          bus.ifid_stall_o  = 1'b1;
          bus.idex_bubble_o = 1'b1;
        end else if (!bus.imem_ack_i) begin
          bus.pc_next_o    = bus.pc_i;
          bus.pc_stall_o   = 1'b1;
          bus.ifid_flush_o = 1'b1;
        end else if (w_rd) begin
          bus.pc_next_o    = w_rd_target;
          bus.ifid_flush_o = 1'b1;
        end else if (r_pend_valid) begin
          bus.pc_next_o    = r_pend_target;
          bus.ifid_flush_o = 1'b1;
        end
      end
      default: begin
        bus.pc_next_o     = RESET_PC;
        bus.pc_stall_o    = 1'b1;
        bus.ifid_flush_o  = 1'b1;
        bus.idex_bubble_o = 1'b1;
      end
    endcase
  end

`ifdef PC_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (r_state != BOOT) begin
      if (bus.pc_stall_o)   r_stall_cnt <= sat_inc(r_stall_cnt);
      if (bus.ifid_flush_o) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
